reaction_ctrl: RTL and testbench

- Round sequencer for the reaction-time tester.
- Function: debounces the start and react buttons, waits a pseudo-random delay, lights the go LED, then counts elapsed milliseconds in 4-digit BCD until the react press.
- Outputs: frozen BCD result plus status flags, fed to the existing 7-segment scan/display block.
- Replaces ad-hoc counting in the top level with an explicit FSM.

---
 rtl/reaction_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/reaction_ctrl.sv | 165 ++++++++++++++++
 tb/tb_reaction_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FOUL  = 3'd4
  } state_e;

  localparam int unsigned BCD_W     = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // One step of the right-shifting Galois LFSR; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge pulse for one raw button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Level follows the synchronized input only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      pulse_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time round sequencer: random pre-go delay, then a BCD millisecond count until react.
// Optional best-time register and display select under `REACTION_BEST_TIME_EN.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter int unsigned RAND_BITS   = 11,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_react,
  input  logic        show_best,
  output logic [15:0] bcd_out,
  output logic        go_led,
  output logic        freeze,
  output logic        foul,
  output logic        busy
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = $clog2(MIN_WAIT_MS + (2 ** RAND_BITS) + 1);

  logic start_p, react_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .btn_i   (btn_start),
    .pulse_o (start_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_react (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .btn_i   (btn_react),
    .pulse_o (react_p)
  );

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q;
  logic [TW-1:0]    tick_q, tick_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
  logic             go_q, freeze_q, foul_q, busy_q;
  logic             tick_c, entry_c, carry_c;
  logic [WW-1:0]    wait_load_c;
  logic [BCD_W-1:0] bcd_inc_c;

`ifdef REACTION_BEST_TIME_EN
  logic [BCD_W-1:0] best_q, best_d;
`endif

  assign tick_c      = (tick_q == TW'(TICK_DIV - 1));
  assign entry_c     = (state_d != state_q) && ((state_d == ST_ARMED) || (state_d == ST_RUN));
  assign tick_d      = (entry_c || tick_c) ? '0 : tick_q + TW'(1);
  assign wait_load_c = WW'(MIN_WAIT_MS) + WW'(lfsr_q[RAND_BITS-1:0]);

  // Decimal increment rippling from d0 to d3.
  always_comb begin
    bcd_inc_c = bcd_q;
    carry_c   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_c) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc_c[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry_c             = 1'b0;
        end
      end
    end
  end

  // Next-state logic; react is evaluated before tick so a coincident press adds no count.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bcd_d   = bcd_q;
`ifdef REACTION_BEST_TIME_EN
    best_d  = best_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start_p) begin
          state_d = ST_ARMED;
          wait_d  = wait_load_c;
          bcd_d   = '0;
        end
      end
      ST_ARMED: begin
        if (react_p) begin
          state_d = ST_FOUL;
          bcd_d   = '0;
        end else if (tick_c) begin
          if (wait_q == WW'(1)) state_d = ST_RUN;
          else                  wait_d  = wait_q - WW'(1);
        end
      end
      ST_RUN: begin
        if (react_p) begin
          state_d = ST_DONE;
`ifdef REACTION_BEST_TIME_EN
          // Packed BCD digits order the same as an unsigned compare, d3 most significant.
          if (bcd_q < best_q) best_d = bcd_q;
`endif
        end else if (tick_c) begin
          bcd_d = bcd_inc_c;
          if (bcd_inc_c == BCD_MAX) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef REACTION_BEST_TIME_EN
  assign bcd_out_d = show_best ? best_d : bcd_d;
`else
  logic unused_show_best;
  assign unused_show_best = show_best;
  assign bcd_out_d        = bcd_d;
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      tick_q    <= '0;
      wait_q    <= '0;
      bcd_q     <= '0;
      bcd_out_q <= '0;
      go_q      <= 1'b0;
      freeze_q  <= 1'b0;
      foul_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_q    <= BCD_MAX;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_step(lfsr_q);
      tick_q    <= tick_d;
      wait_q    <= wait_d;
      bcd_q     <= bcd_d;
      bcd_out_q <= bcd_out_d;
      go_q      <= (state_d == ST_RUN);
      freeze_q  <= (state_d == ST_DONE);
      foul_q    <= (state_d == ST_FOUL);
      busy_q    <= (state_d == ST_ARMED) || (state_d == ST_RUN);
`ifdef REACTION_BEST_TIME_EN
      best_q    <= best_d;
`endif
    end
  end

  assign bcd_out = bcd_out_q;
  assign go_led  = go_q;
  assign freeze  = freeze_q;
  assign foul    = foul_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with small timing parameters.
module tb_reaction_ctrl;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic        show_best = 1'b0;
  logic [15:0] bcd_out;
  logic        go_led, freeze, foul, busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr;
  logic [15:0] lf;
  logic [15:0] lf_unused;
  logic        seen_go;

  reaction_ctrl #(
    .TICK_DIV    (4),
    .MIN_WAIT_MS (3),
    .RAND_BITS   (2),
    .DEB_CYCLES  (2)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_react (btn_react),
    .show_best (show_best),
    .bcd_out   (bcd_out),
    .go_led    (go_led),
    .freeze    (freeze),
    .foul      (foul),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  // Reference LFSR: seed 0xACE1, Galois taps 0xB400, one step per clock.
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Press at edge k+1ns; the FSM acts at edge k+5. Returns 1ns after that edge with the LFSR it used.
  task automatic press(input bit is_start, output logic [15:0] lfo);
    if (is_start) btn_start = 1'b1;
    else          btn_react = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 lfo = m_lfsr;
    @(posedge sysclk);
    #1;
    btn_start = 1'b0;
    btn_react = 1'b0;
  endtask

  task automatic wait_go(input string tag, input logic [15:0] lfv);
    int n = 0;
    while (go_led !== 1'b1 && n < 200) begin
      @(posedge sysclk);
      #1 n++;
    end
    check(tag, 32'(n), 32'(4 * (3 + int'(lfv[1:0]))));
  endtask

  // React so the FSM acts at edge R+4n+j, where R is the edge go_led rose.
  task automatic react_at(input int n, input int j);
    repeat (4 * n + j - 5) @(posedge sysclk);
    #1 press(1'b0, lf_unused);
  endtask

  task automatic check_done(input string tag, input logic [15:0] exp);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
    check({tag, "_freeze"}, 32'(freeze), 32'd1);
    check({tag, "_go"}, 32'(go_led), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_go", 32'(go_led), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_foul", 32'(foul), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;

    // Foul: react during ARMED, then a fresh start clears it.
    press(1'b1, lf);
    check("arm_busy", 32'(busy), 32'd1);
    press(1'b0, lf_unused);
    check("foul_flag", 32'(foul), 32'd1);
    check("foul_bcd", 32'(bcd_out), 32'h0);
    check("foul_busy", 32'(busy), 32'd0);
    seen_go = 1'b0;
    repeat (60) begin
      @(posedge sysclk);
      #1 if (go_led) seen_go = 1'b1;
    end
    check("foul_no_go", 32'(seen_go), 32'd0);
    press(1'b1, lf);
    check("refoul_clear", 32'(foul), 32'd0);
    check("refoul_busy", 32'(busy), 32'd1);
    wait_go("go_delay_a", lf);

    // React 5 ticks after go, then hold.
    react_at(5, 2);
    check_done("r5", 16'h0005);
    repeat (1000) @(posedge sysclk);
    #1;
    check("r5_hold_bcd", 32'(bcd_out), 32'h0005);
    check("r5_hold_freeze", 32'(freeze), 32'd1);

    // React coincident with the tick that would make 0010.
    press(1'b1, lf);
    check("done_restart_freeze", 32'(freeze), 32'd0);
    check("done_restart_bcd", 32'(bcd_out), 32'h0);
    wait_go("go_delay_b", lf);
    react_at(9, 4);
    check_done("r9_align", 16'h0009);

    // Decimal carry 0099 -> 0100, react lands after tick 101.
    press(1'b1, lf);
    wait_go("go_delay_c", lf);
    repeat (398) @(posedge sysclk);
    #1 check("carry_0099", 32'(bcd_out), 32'h0099);
    repeat (4) @(posedge sysclk);
    #1 check("carry_0100", 32'(bcd_out), 32'h0100);
    press(1'b0, lf_unused);
    check_done("r101", 16'h0101);

    // One-cycle glitches produce no pulses; then reset mid-RUN.
    press(1'b1, lf);
    wait_go("go_delay_d", lf);
    btn_react = 1'b1;
    btn_start = 1'b1;
    @(posedge sysclk);
    #1;
    btn_react = 1'b0;
    btn_start = 1'b0;
    repeat (10) @(posedge sysclk);
    #1;
    check("glitch_go", 32'(go_led), 32'd1);
    check("glitch_freeze", 32'(freeze), 32'd0);
    check("glitch_bcd", 32'(bcd_out), 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    check("midrst_go", 32'(go_led), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_freeze", 32'(freeze), 32'd0);
    check("midrst_foul", 32'(foul), 32'd0);
    @(posedge sysclk);
    #1 rst_n = 1'b1;
    press(1'b0, lf_unused);
    check("idle_react_foul", 32'(foul), 32'd0);
    check("idle_react_busy", 32'(busy), 32'd0);

    // Rounds of 0012, 0007, then a timeout.
    press(1'b1, lf);
    check("b1_busy", 32'(busy), 32'd1);
    wait_go("go_delay_e", lf);
    react_at(12, 2);
    check_done("r12", 16'h0012);
    show_best = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 check("r12_show", 32'(bcd_out), 32'h0012);
    show_best = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;

    press(1'b1, lf);
    wait_go("go_delay_f", lf);
    react_at(7, 3);
    check_done("r7", 16'h0007);
    show_best = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 check("r7_show", 32'(bcd_out), 32'h0007);
    show_best = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;

    press(1'b1, lf);
    wait_go("go_delay_g", lf);
    begin
      int n = 0;
      while (freeze !== 1'b1 && n < 41000) begin
        @(posedge sysclk);
        #1 n++;
      end
      check("timeout_cycles", 32'(n), 32'd39996);
    end
    check_done("timeout", 16'h9999);
    show_best = 1'b1;
    repeat (3) @(posedge sysclk);
`ifdef REACTION_BEST_TIME_EN
    #1 check("timeout_show_best", 32'(bcd_out), 32'h0007);
`else
    #1 check("timeout_show_ignored", 32'(bcd_out), 32'h9999);
`endif
    show_best = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 check("timeout_live", 32'(bcd_out), 32'h9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
